// File: rtl/mem_loader.sv
// Byte-stream program loader for the multi-cycle MIPS: assembles big-endian words, writes memory, releases CPU reset.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef LOADER_CHECKSUM_EN
    ,S_CSUM  = 3'd7
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        word_cnt_q, word_cnt_d;
  logic [BCNT_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]       wdata_q, wdata_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    mem_we_q, mem_we_d;
  logic                    cpu_rstn_q, cpu_rstn_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    xfer_c;
  logic [LEN_W-1:0]        len_full_c;
  logic [LEN_W-1:0]        word_cnt_inc_c;
  state_e                  end_state_c;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]       csum_q, csum_d;
`endif

  assign xfer_c         = rx_valid && rx_ready_q;
  assign len_full_c     = {len_q[LEN_W-1:BYTE_W], rx_data};
  assign word_cnt_inc_c = word_cnt_q + LEN_W'(1);

  // Where a load goes once all words are written (or immediately for N==0).
`ifdef LOADER_CHECKSUM_EN
  assign end_state_c = S_CSUM;
`else
  assign end_state_c = S_DONE;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      cpu_rstn_q <= cpu_rstn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d   = {rx_data, len_q[BYTE_W-1:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d = len_full_c;
          if (len_full_c == '0) begin
            state_d = end_state_c;
          end else if (32'(len_full_c) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          wdata_d    = {wdata_q[WORD_W-BYTE_W-1:0], rx_data};
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_data;
`endif
          if (byte_cnt_q == BCNT_W'(3)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // Strobe is already out this cycle with the pre-increment address.
        addr_d     = addr_q + ADDR_WIDTH'(1);
        word_cnt_d = word_cnt_inc_c;
        state_d    = (word_cnt_inc_c == len_q) ? end_state_c : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_c) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    rx_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    cpu_rstn_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        mem_we_d = 1'b1;
        busy_d   = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`endif
      S_DONE: begin
        done_d     = 1'b1;
        cpu_rstn_d = 1'b1;
      end
      S_ERR:   err_d = 1'b1;
      default: ;
    endcase
  end

  assign rx_ready  = rx_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rstn  = cpu_rstn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: stream framing, stalls, length error, mid-load reset, optional checksum.
module tb_mem_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid, rx_ready, mem_we, cpu_rstn, busy, done, err;
  logic [7:0]    rx_data;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  mem_loader #(.ADDR_WIDTH(AW), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int wr_n  = 0;
  int base;
  logic [31:0]   wr_data [64];
  logic [AW-1:0] wr_addr [64];
  int            wr_cyc  [64];
  logic [7:0]    s [$];
  bit            ph;

  // Write log, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_we && wr_n < 64) begin
      wr_data[wr_n] = mem_wdata;
      wr_addr[wr_n] = mem_addr;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one byte until the loader is ready for it.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    bit sent = 1'b0;
    while (!sent && n < 200) begin
      if (toggle && ph) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        sent     = rx_ready;
      end
      if (toggle) ph = !ph;
      @(negedge clk);
      n++;
    end
    if (!sent) check("byte_timeout", 32'(sent), 32'd1);
  endtask

  task automatic send_stream(input bit toggle);
    ph = 1'b0;
    foreach (s[i]) send_byte(s[i], toggle);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic check_two_words(input string pfx);
    check({pfx, "_nwr"},   32'(wr_n - base), 32'd2);
    check({pfx, "_a0"},    32'(wr_addr[base]), 32'd0);
    check({pfx, "_d0"},    wr_data[base], 32'h12345678);
    check({pfx, "_a1"},    32'(wr_addr[base+1]), 32'd1);
    check({pfx, "_d1"},    wr_data[base+1], 32'h9ABCDEF0);
    check({pfx, "_done"},  32'(done), 32'd1);
    check({pfx, "_rstn"},  32'(cpu_rstn), 32'd1);
    check({pfx, "_busy"},  32'(busy), 32'd0);
    check({pfx, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Idle after reset
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rstn",  32'(cpu_rstn), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_nwr",   32'(wr_n), 32'd0);

    // Two words at full rate
    base = wr_n;
    s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    pulse_start();
    check("full_busy", 32'(busy), 32'd1);
    send_stream(1'b0);
    repeat (3) @(negedge clk);
    check_two_words("full");
    check("full_gap", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);

    // Same stream with rx_valid toggling
    base = wr_n;
    pulse_start();
    check("tog_done_clr", 32'(done), 32'd0);
    check("tog_rstn_clr", 32'(cpu_rstn), 32'd0);
    send_stream(1'b1);
    repeat (3) @(negedge clk);
    check_two_words("tog");

    // Zero-length load
    base = wr_n;
    s = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h00);
`endif
    pulse_start();
    send_stream(1'b0);
    repeat (2) @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_nwr",  32'(wr_n - base), 32'd0);

    // Length one past DEPTH
    base = wr_n;
    s = '{8'h04, 8'h01};
    pulse_start();
    send_stream(1'b0);
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) @(negedge clk);
    check("len_err",   32'(err), 32'd1);
    check("len_rstn",  32'(cpu_rstn), 32'd0);
    check("len_ready", 32'(rx_ready), 32'd0);
    check("len_busy",  32'(busy), 32'd0);
    check("len_done",  32'(done), 32'd0);
    check("len_nwr",   32'(wr_n - base), 32'd0);
    rx_valid = 1'b0;

    // Reset after two of four words; a stray start mid-load is ignored
    base = wr_n;
    pulse_start();
    s = '{8'h00, 8'h04};
    send_stream(1'b0);
    pulse_start();
    s = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stream(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_nwr",   32'(wr_n - base), 32'd2);
    check("mid_a1",    32'(wr_addr[base+1]), 32'd1);
    check("mid_ready", 32'(rx_ready), 32'd0);
    check("mid_addr",  32'(mem_addr), 32'd0);
    check("mid_wdata", mem_wdata, 32'd0);
    check("mid_busy",  32'(busy), 32'd0);
    check("mid_rstn",  32'(cpu_rstn), 32'd0);
    check("mid_done",  32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    base = wr_n;
    s = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
`ifdef LOADER_CHECKSUM_EN
    s.push_back(8'h04);
`endif
    pulse_start();
    send_stream(1'b0);
    repeat (3) @(negedge clk);
    check("re_nwr",  32'(wr_n - base), 32'd1);
    check("re_a0",   32'(wr_addr[base]), 32'd0);
    check("re_d0",   wr_data[base], 32'hA1B2C3D4);
    check("re_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    base = wr_n;
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    pulse_start();
    send_stream(1'b0);
    repeat (2) @(negedge clk);
    check("cs_ok_done", 32'(done), 32'd1);
    check("cs_ok_err",  32'(err), 32'd0);
    base = wr_n;
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    pulse_start();
    send_stream(1'b0);
    repeat (2) @(negedge clk);
    check("cs_bad_err",  32'(err), 32'd1);
    check("cs_bad_rstn", 32'(cpu_rstn), 32'd0);
    check("cs_bad_nwr",  32'(wr_n - base), 32'd1);
    check("cs_bad_a0",   32'(wr_addr[base]), 32'd0);
    check("cs_bad_d0",   wr_data[base], 32'h11223344);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
